// File: rtl/instr_fetch_if.sv
// Instruction memory read port shared by the fetch stage and the memory.
// The fetcher drives address/request; the memory returns data/valid.
interface instr_fetch_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [15:0]       mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rdata,
    output mem_rvalid
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the pc, reads 16-bit words from instruction memory,
// and hands them downstream, stepped by a button or free-running.
module instr_fetch #(
  parameter int           ADDR_W   = 8,
  parameter logic [7:0]   RESET_PC = 8'h00,
  parameter int           TIMEOUT  = 15,
  parameter logic [3:0]   HALT_OP  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_mode,
  input  logic              manual_plus,
  instr_fetch_if.master     mem,
  output logic [15:0]       order,
  output logic              order_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [2:0]        sync_q;
  logic              step_evt;
  logic              step_pend_q, step_pend_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       order_q, order_d;
  logic              ov_q, ov_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic              trigger;
  logic              take;

  // Button: two-flop synchroniser plus one history flop for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], manual_plus};
    end
  end

  assign step_evt = sync_q[1] & ~sync_q[2];
  assign trigger  = ~halted_q & (run_mode | step_pend_q);
  assign take     = (state_q == IDLE) & trigger;

  // One-deep step request; edges landing while it is pending are dropped.
  always_comb begin
    step_pend_d = step_pend_q;
    if (take) begin
      step_pend_d = 1'b0;
    end else if (step_evt && !run_mode) begin
      step_pend_d = 1'b1;
    end
  end

  // Next-state, datapath updates and sticky flags.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    order_d    = order_q;
    ov_d       = 1'b0;
    halted_d   = halted_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        wait_cnt_d = 8'd0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          order_d  = mem.mem_rdata;
          ov_d     = 1'b1;
          pc_d     = pc_q + ADDR_W'(1);
          halted_d = halted_q |
                     (mem.mem_rdata[15:12] == HALT_OP);
          state_d  = IDLE;
        end else if (wait_cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_pend_q <= 1'b0;
      wait_cnt_q  <= 8'd0;
      pc_q        <= ADDR_W'(RESET_PC);
      addr_q      <= '0;
      order_q     <= 16'h0000;
      ov_q        <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_pend_q <= step_pend_d;
      wait_cnt_q  <= wait_cnt_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      order_q     <= order_d;
      ov_q        <= ov_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_rd_en = (state_q == REQ);
  assign mem.mem_addr  = addr_q;
  assign order         = order_q;
  assign order_valid   = ov_q;
  assign pc            = pc_q;
  assign busy          = (state_q != IDLE);
  assign halted        = halted_q;
  assign fetch_err     = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random manual fetches
// checked against a transaction-level model of the fetch rules.
module tb_instr_fetch;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run_mode = 1'b0;
  logic          manual_plus = 1'b0;
  logic [15:0]   order;
  logic          order_valid;
  logic [AW-1:0] pc;
  logic          busy, halted, fetch_err;

  instr_fetch_if #(.ADDR_W(AW)) bus ();

  instr_fetch #(
    .ADDR_W(AW), .RESET_PC(8'h00),
    .TIMEOUT(TO), .HALT_OP(4'hF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .run_mode(run_mode), .manual_plus(manual_plus),
    .mem(bus),
    .order(order), .order_valid(order_valid),
    .pc(pc), .busy(busy),
    .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  logic [15:0]   mem [256];
  int            lat_cfg = 0;
  bit            mute = 0;
  bit            force_rv = 0;
  int            nreq = 0;
  int            cyc = 0;
  bit            act = 0;
  int            cnt = 0;
  logic [AW-1:0] raddr;
  bit            rd;
  logic [AW-1:0] ra;

  logic [AW-1:0] e_pc;
  logic [15:0]   e_order;
  bit            e_halt, e_err;
  int            n_pass = 0;
  int            n_chk = 0;

  always @(posedge clk) cyc++;

  // Memory: answers a request lat_cfg cycles after the first WAIT cycle.
  always begin
    @(posedge clk);
    rd = bus.mem_rd_en;
    ra = bus.mem_addr;
    #1;
    if (!rst_n) begin
      act = 0;
    end else if (rd) begin
      act = 1; cnt = lat_cfg; raddr = ra; nreq++;
    end
    bus.mem_rvalid = 1'b0;
    if (act) begin
      if (cnt == 0) begin
        bus.mem_rvalid = !mute;
        bus.mem_rdata  = mem[raddr];
        act = 0;
      end else begin
        cnt--;
      end
    end
    if (force_rv) bus.mem_rvalid = 1'b1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic press();
    @(negedge clk);
    manual_plus = 1'b1;
    repeat (2) @(negedge clk);
    manual_plus = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.mem_rd_en) ok = 1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_order"}, order, 16'h0000);
    chk({tag, "_ov"}, order_valid, 1'b0);
    chk({tag, "_pc"}, pc, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_halted"}, halted, 1'b0);
    chk({tag, "_err"}, fetch_err, 1'b0);
    chk({tag, "_rden"}, bus.mem_rd_en, 1'b0);
    chk({tag, "_addr"}, bus.mem_addr, 8'h00);
  endtask

  function automatic logic [15:0] rnd_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == 4'hF) w[15] = 1'b0;
    return w;
  endfunction

  // One fetch: the model predicts outcome, timing and resulting state.
  task automatic fetch(input bit do_press, input int lat, input bit nores,
                       input bit busy_press, output int rc);
    bit ok, succ, err_before;
    int target, nov, first, n0;
    logic [15:0] w;
    lat_cfg = lat;
    mute = nores;
    rc = 0;
    n0 = nreq;
    if (do_press) press();
    wait_req(ok);
    chk("req_seen", ok, 1);
    if (!ok) return;
    rc = cyc;
    chk("req_addr", bus.mem_addr, e_pc);
    chk("busy_req", busy, 1'b1);
    succ = !nores && (lat <= TO - 1);
    target = succ ? lat + 2 : TO + 1;
    nov = 0; first = 0; err_before = 0;
    for (int n = 1; n <= target; n++) begin
      @(negedge clk);
      if (busy_press) manual_plus = (n == 1 || n == 2 || n == 5 || n == 6);
      if (order_valid) begin
        nov++;
        if (first == 0) first = n;
      end
      if (n == target - 1) err_before = fetch_err;
    end
    if (succ) begin
      w = mem[e_pc];
      e_order = w;
      e_pc = e_pc + 1'b1;
      if (w[15:12] == 4'hF) e_halt = 1;
      chk("ov_count", nov, 1);
      chk("ov_time", first, target);
    end else begin
      if (!e_err) chk("err_time", err_before, 1'b0);
      e_err = 1;
      chk("ov_none", nov, 0);
    end
    chk("one_req", nreq - n0, 1);
    chk("order", order, e_order);
    chk("pc", pc, e_pc);
    chk("halted", halted, e_halt);
    chk("fetch_err", fetch_err, e_err);
  endtask

  task automatic model_reset();
    e_pc = 0; e_order = 0; e_halt = 0; e_err = 0;
  endtask

  initial begin
    int rc, n0, nov, t0, t1, t2;
    bit ok;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0000;
    model_reset();

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Manual single step
    mem[0] = 16'h7A40;
    fetch(1, 0, 0, 0, rc);
    n0 = nreq;
    repeat (20) @(negedge clk);
    chk("manual_no_more", nreq, n0);

    // Timeout, then retry of the same address
    mem[1] = 16'h1234;
    fetch(1, 0, 1, 0, rc);
    fetch(1, 0, 0, 0, rc);

    // Latency boundary: last WAIT cycle succeeds, one later times out
    mem[2] = 16'h2468;
    fetch(1, TO - 1, 0, 0, rc);
    mem[3] = 16'h3579;
    fetch(1, TO, 0, 0, rc);

    // Two button edges during one busy fetch give one extra fetch
    mem[4] = 16'h4111;
    fetch(1, 14, 0, 1, rc);
    manual_plus = 1'b0;
    mem[5] = 16'h5222;
    fetch(0, 0, 0, 0, rc);
    n0 = nreq;
    repeat (30) @(negedge clk);
    chk("busy_press_once", nreq, n0);

    // Sub-cycle glitch never sampled high
    n0 = nreq;
    @(negedge clk);
    #1 manual_plus = 1'b1;
    #2 manual_plus = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_ignored", nreq, n0);

    // Random manual fetches with random latency
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      mem[e_pc] = rnd_word();
      fetch(1, int'($urandom_range(0, TO + 2)), 0, 0, rc);
    end

    // Reset in the middle of WAIT; late rvalid ignored
    mute = 1;
    lat_cfg = 0;
    press();
    wait_req(ok);
    chk("rstw_req", ok, 1);
    repeat (3) @(negedge clk);
    chk("rstw_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rstw");
    model_reset();
    mute = 0;
    n0 = nreq;
    force_rv = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nov = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (order_valid) nov++;
    end
    force_rv = 0;
    chk("rstw_late_rv", nov, 0);
    chk("rstw_no_req", nreq, n0);
    chk("rstw_pc", pc, 8'h00);

    // Free run with zero-wait memory ending in a halt
    mem[0] = 16'h7100;
    mem[1] = 16'h8600;
    mem[2] = 16'hF000;
    run_mode = 1'b1;
    fetch(0, 0, 0, 0, t0);
    fetch(0, 0, 0, 0, t1);
    fetch(0, 0, 0, 0, t2);
    chk("fr_gap1", t1 - t0, 3);
    chk("fr_gap2", t2 - t1, 3);
    n0 = nreq;
    repeat (30) @(negedge clk);
    chk("halt_no_req", nreq, n0);
    chk("halt_idle", busy, 1'b0);
    run_mode = 1'b0;

    // pc wrap across 256 free-run fetches
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("wrap_halt_clr", halted, 1'b0);
    for (int i = 0; i < 256; i++) mem[i] = rnd_word();
    mem[255] = 16'h7000;
    run_mode = 1'b1;
    for (int i = 0; i < 256; i++) fetch(0, 0, 0, 0, rc);
    run_mode = 1'b0;
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_order", order, 16'h7000);
    n0 = nreq;
    repeat (10) @(negedge clk);
    chk("wrap_stop", nreq, n0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
